pisca_leds_multi: RTL and testbench

Multi-channel, parametrised LED blinker: the successor to the single-LED toggle blinker. Each of `N_CH` channels has its own mode, programmable half-period and burst count, set through a one-cycle write port. The block sits between board LEDs and the control logic (or a testbench driver) and generates steady, continuous-blink or counted-burst patterns on all channels at once, each independent of the others.

---
 rtl/pisca_leds_multi.sv | 132 +++++++++++++
 tb/tb_pisca_leds_multi.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pisca_leds_multi.sv
// Multi-channel LED blinker: per-channel OFF / ON / BLINK / BURST patterns set via a one-cycle write port.
// Define PISCA_LEDS_ACTIVE_LOW_EN to drive led_out inverted for active-low board LEDs.
module pisca_leds_multi #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned BURST_W = 8
) (
  input  logic                                        clk_in1,
  input  logic                                        rst_in1,
  input  logic                                        cfg_we,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]  cfg_ch,
  input  logic [1:0]                                  cfg_mode,
  input  logic [CNT_W-1:0]                            cfg_half,
  input  logic [BURST_W-1:0]                          cfg_count,
  output logic [N_CH-1:0]                             led_out,
  output logic [N_CH-1:0]                             busy_out
);

  localparam logic [1:0] S_OFF = 2'd0;
  localparam logic [1:0] S_ON  = 2'd1;
  localparam logic [1:0] S_HI  = 2'd2;
  localparam logic [1:0] S_LO  = 2'd3;

  localparam logic [1:0] M_OFF   = 2'b00;
  localparam logic [1:0] M_ON    = 2'b01;
  localparam logic [1:0] M_BLINK = 2'b10;
  localparam logic [1:0] M_BURST = 2'b11;

`ifdef PISCA_LEDS_ACTIVE_LOW_EN
  localparam logic LED_INV = 1'b1;
`else
  localparam logic LED_INV = 1'b0;
`endif

  logic [1:0]         st_q    [N_CH];
  logic [1:0]         st_d    [N_CH];
  logic               burst_q [N_CH];
  logic               burst_d [N_CH];
  logic [CNT_W-1:0]   half_q  [N_CH];
  logic [CNT_W-1:0]   half_d  [N_CH];
  logic [CNT_W-1:0]   cnt_q   [N_CH];
  logic [CNT_W-1:0]   cnt_d   [N_CH];
  logic [BURST_W-1:0] rem_q   [N_CH];
  logic [BURST_W-1:0] rem_d   [N_CH];
  logic [N_CH-1:0]    led_q,  led_d;
  logic [N_CH-1:0]    busy_q, busy_d;

  logic [CNT_W-1:0]   half_eff_c;

  // A zero half-period is stored as one so phases always last at least a cycle.
  assign half_eff_c = (cfg_half == '0) ? CNT_W'(1) : cfg_half;

  // Next-state per channel: a write restarts the channel, otherwise phases run on.
  always_comb begin
    st_d    = st_q;
    burst_d = burst_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    led_d   = '0;
    busy_d  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (cfg_we && (32'(cfg_ch) == i)) begin
        burst_d[i] = 1'b0;
        case (cfg_mode)
          M_OFF:   st_d[i] = S_OFF;
          M_ON:    st_d[i] = S_ON;
          M_BLINK: begin
            st_d[i]   = S_HI;
            half_d[i] = half_eff_c;
            cnt_d[i]  = half_eff_c - CNT_W'(1);
          end
          M_BURST: begin
            if (cfg_count == '0) begin
              st_d[i] = S_OFF;
            end else begin
              st_d[i]    = S_HI;
              burst_d[i] = 1'b1;
              half_d[i]  = half_eff_c;
              cnt_d[i]   = half_eff_c - CNT_W'(1);
              rem_d[i]   = cfg_count;
            end
          end
          default: st_d[i] = S_OFF;
        endcase
      end else if (st_q[i] == S_HI || st_q[i] == S_LO) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end else begin
          cnt_d[i] = half_q[i] - CNT_W'(1);
          if (st_q[i] == S_HI) begin
            st_d[i] = S_LO;
            if (burst_q[i] && rem_q[i] != '0) rem_d[i] = rem_q[i] - BURST_W'(1);
          end else if (burst_q[i] && rem_q[i] == '0) begin
            st_d[i]    = S_OFF;
            burst_d[i] = 1'b0;
          end else begin
            st_d[i] = S_HI;
          end
        end
      end
      led_d[i]  = LED_INV ^ ((st_d[i] == S_ON) || (st_d[i] == S_HI));
      busy_d[i] = burst_d[i] && ((st_d[i] == S_HI) || (st_d[i] == S_LO));
    end
  end

  always_ff @(posedge clk_in1) begin
    if (rst_in1) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        st_q[i]    <= S_OFF;
        burst_q[i] <= 1'b0;
        half_q[i]  <= '0;
        cnt_q[i]   <= '0;
        rem_q[i]   <= '0;
      end
      led_q  <= {N_CH{LED_INV}};
      busy_q <= '0;
    end else begin
      st_q    <= st_d;
      burst_q <= burst_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign led_out  = led_q;
  assign busy_out = busy_q;

endmodule

// File: tb/tb_pisca_leds_multi.sv
// Randomised bench for pisca_leds_multi against a time-based pattern model.
// Uses five channels so that out-of-range channel numbers are expressible.
module tb_pisca_leds_multi;

  localparam int NCH  = 5;
  localparam int CH_W = 3;
  localparam int CW   = 16;
  localparam int BW   = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            we = 1'b0;
  logic [CH_W-1:0] ch = '0;
  logic [1:0]      mode = '0;
  logic [CW-1:0]   half = '0;
  logic [BW-1:0]   count = '0;
  logic [NCH-1:0]  led_out, busy_out;

  int checks = 0;
  int failures = 0;

  // Model: each channel remembers its mode, write edge, half-period and pulse count.
  int m_mode [NCH];
  int m_k    [NCH];
  int m_h    [NCH];
  int m_n    [NCH];
  int t = 0;

  pisca_leds_multi #(.N_CH(NCH), .CNT_W(CW), .BURST_W(BW)) dut (
    .clk_in1(clk), .rst_in1(rst), .cfg_we(we), .cfg_ch(ch), .cfg_mode(mode),
    .cfg_half(half), .cfg_count(count), .led_out(led_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  function automatic logic [NCH-1:0] exp_led();
    logic [NCH-1:0] v = '0;
    for (int c = 0; c < NCH; c++) begin
      int d = t - m_k[c];
      case (m_mode[c])
        1: v[c] = 1'b1;
        2: v[c] = ((d / m_h[c]) % 2) == 0;
        3: v[c] = (d < 2 * m_n[c] * m_h[c]) && (((d / m_h[c]) % 2) == 0);
        default: v[c] = 1'b0;
      endcase
    end
`ifdef PISCA_LEDS_ACTIVE_LOW_EN
    v = ~v;
`endif
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_busy();
    logic [NCH-1:0] v = '0;
    for (int c = 0; c < NCH; c++)
      v[c] = (m_mode[c] == 3) && ((t - m_k[c]) < 2 * m_n[c] * m_h[c]);
    return v;
  endfunction

  // Apply one cycle of inputs, update the model for that edge, then compare.
  task automatic step(input logic r, input logic w, input int c, input int md,
                      input int h, input int n, input string tag);
    rst = r; we = w; ch = CH_W'(c); mode = 2'(md); half = CW'(h); count = BW'(n);
    @(posedge clk);
    t++;
    if (r) begin
      for (int i = 0; i < NCH; i++) m_mode[i] = 0;
    end else if (w && c < NCH) begin
      m_k[c] = t;
      m_h[c] = (h == 0) ? 1 : h;
      m_n[c] = n;
      m_mode[c] = (md == 3 && n == 0) ? 0 : md;
    end
    #1;
    check({tag, "_led"}, 32'(led_out), 32'(exp_led()));
    check({tag, "_busy"}, 32'(busy_out), 32'(exp_busy()));
    we = 1'b0;
  endtask

  task automatic idle(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    int hi_cnt;
    int busy_cnt;
    logic [NCH-1:0] led_prev;
    logic [NCH-1:0] busy_prev;
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = 0; m_k[i] = 0; m_h[i] = 1; m_n[i] = 0;
    end

    // Reset held three cycles with a write pulsed alongside.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, i, 1, 3, 2, "reset");
    step(1'b0, 1'b0, 0, 0, 0, 0, "reset_rel");
    check("reset_busy_const", 32'(busy_out), 32'(0));

    // Steady modes.
    step(1'b0, 1'b1, 0, 1, 0, 0, "on0");
    check("on0_const", 32'(led_out[3:0]), 32'(4'b0001));
    step(1'b0, 1'b1, 1, 1, 0, 0, "on1");
    check("on1_const", 32'(led_out[3:0]), 32'(4'b0011));
    step(1'b0, 1'b1, 0, 0, 0, 0, "off0");
    check("off0_const", 32'(led_out[3:0]), 32'(4'b0010));
    step(1'b0, 1'b1, 1, 0, 0, 0, "off1");

    // BLINK H=3 on ch2, then half=0 on ch1.
    step(1'b0, 1'b1, 2, 2, 3, 0, "blink3");
    idle(59, "blink3");
    step(1'b0, 1'b1, 1, 2, 0, 0, "blink0");
    idle(9, "blink0");
    step(1'b0, 1'b1, 2, 0, 0, 0, "off2");
    step(1'b0, 1'b1, 1, 0, 0, 0, "off1b");

    // BURST N=4 H=2 on ch3: count high and busy cycles over a 20-cycle window.
    hi_cnt = 0; busy_cnt = 0;
    step(1'b0, 1'b1, 3, 3, 2, 4, "burst");
    if (led_out[3]) hi_cnt++;
    if (busy_out[3]) busy_cnt++;
    for (int i = 0; i < 19; i++) begin
      step(1'b0, 1'b0, 0, 0, 0, 0, "burst");
      if (led_out[3]) hi_cnt++;
      if (busy_out[3]) busy_cnt++;
    end
    check("burst_hi_cycles", 32'(hi_cnt), 32'(8));
    check("burst_busy_cycles", 32'(busy_cnt), 32'(16));
    step(1'b0, 1'b1, 0, 3, 2, 0, "burst0");
    idle(4, "burst0");
    check("burst0_led", 32'(led_out[0]), 32'(0));

    // Rewrite mid-burst, then an out-of-range write.
    step(1'b0, 1'b1, 3, 3, 4, 5, "reburst");
    idle(7, "reburst");
    step(1'b0, 1'b1, 3, 2, 1, 0, "rewrite");
    check("rewrite_busy", 32'(busy_out[3]), 32'(0));
    idle(6, "rewrite");
    led_prev = led_out; busy_prev = busy_out;
    step(1'b0, 1'b1, NCH, 1, 0, 0, "oor");
    check("oor_unchanged", 32'(led_out[2:0]), 32'(led_prev[2:0]));
    check("oor_busy", 32'(busy_out), 32'(busy_prev));

    // Random traffic with occasional resets and out-of-range channels.
    for (int i = 0; i < 1500; i++) begin
      logic r;
      logic w;
      r = ($urandom_range(0, 99) == 0);
      w = ($urandom_range(0, 9) < 3);
      step(r, w, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 6)), int'($urandom_range(0, 5)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
